// File: rtl/synth_pkg.sv
`default_nettype none
// ============================================================================
// Module      : synth_pkg
// Description : Shared constants for the step-note synthesiser: note count,
//               square-wave half-period table (equal temperament, A4 = 440 Hz,
//               characterised at a 50 MHz reference clock) and the gate FSM
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package synth_pkg;

    localparam int NOTE_COUNT = 12;
    localparam int HALF_W     = 17;

    // Clock rate the half-period table below was computed for.
    localparam int unsigned REF_CLK_HZ = 50_000_000;

    // Index 0 = C4 ... index 11 = B4; value = round(REF_CLK_HZ / (2 * f_note)).
    localparam logic [HALF_W-1:0] HALF_PERIOD [NOTE_COUNT] = '{
        17'd95556, 17'd90193, 17'd85131, 17'd80353,
        17'd75843, 17'd71586, 17'd67568, 17'd63776,
        17'd60196, 17'd56818, 17'd53629, 17'd50619
    };

    typedef enum logic [0:0] {
        GATE_IDLE  = 1'b0,
        GATE_SOUND = 1'b1
    } gate_state_e;

    // Rescales a reference half-period to the actual system clock. At the
    // reference rate this returns the table value unchanged.
    function automatic logic [HALF_W-1:0] scale_half(input logic [HALF_W-1:0] half,
                                                     input int unsigned       clk_hz);
        return HALF_W'((64'(half) * 64'(clk_hz)) / 64'(REF_CLK_HZ));
    endfunction

endpackage
`default_nettype wire

// File: rtl/step_note_synth_if.sv
`default_nettype none
// ============================================================================
// Module      : step_note_synth_if
// Description : Sample hand-off to the audio codec (valid/ready).
//   sample       : signed 24-bit mono sample, source -> sink
//   sample_valid : sample holds unaccepted data, source -> sink
//   sample_ready : sink accepts on a clock edge while high, sink -> source
// Revision    : 1.0 - initial release
// ============================================================================
interface step_note_synth_if;
    logic signed [23:0] sample;
    logic               sample_valid;
    logic               sample_ready;

    modport master (output sample, output sample_valid, input  sample_ready);
    modport slave  (input  sample, input  sample_valid, output sample_ready);
endinterface
`default_nettype wire

// File: rtl/tone_osc.sv
`default_nettype none
// ============================================================================
// Module      : tone_osc
// Description : One square-wave oscillator. While enabled the phase toggles
//               every HALF clocks; while disabled the counter and phase are
//               parked so the note always restarts phase-aligned.
// Ports       : CLOCK_50 (clk), Reset (async, active-high),
//               enable (note sounding), phase (square-wave output, 0 = low)
// Revision    : 1.0 - initial release
// ============================================================================
module tone_osc #(
    parameter logic [16:0] HALF = 17'd56818
) (
    input  wire  CLOCK_50,
    input  wire  Reset,
    input  wire  enable,
    output logic phase
);

    localparam logic [16:0] RELOAD = HALF - 17'd1;

    logic [16:0] cnt_q, cnt_d;
    logic        phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!enable) begin
            cnt_d   = RELOAD;
            phase_d = 1'b0;
        end else if (cnt_q == 17'd0) begin
            cnt_d   = RELOAD;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q - 17'd1;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            cnt_q   <= RELOAD;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule
`default_nettype wire

// File: rtl/step_note_synth.sv
`default_nettype none
// ============================================================================
// Module      : step_note_synth
// Description : Audio back end of the step sequencer. Latches the 12-bit note
//               mask on each synchronised BPM step, runs one square-wave
//               oscillator per active note, mixes them into a signed 24-bit
//               sample every SAMPLE_DIV clocks and offers it to the codec.
// Ports       : CLOCK_50, Reset (async, active-high)
//               select_note[11:0], bpm_step (async), play_en
//               active_notes[11:0], overrun (sticky drop flag)
//               snd : step_note_synth_if.master (sample / valid / ready)
// Revision    : 1.0 - initial release
// ============================================================================
module step_note_synth
    import synth_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned SAMPLE_DIV  = 1042,
    parameter int          AMP         = 600_000,
    parameter int unsigned GATE_CYCLES = 0
) (
    input  wire                         CLOCK_50,
    input  wire                         Reset,
    input  wire  [NOTE_COUNT-1:0]       select_note,
    input  wire                         bpm_step,
    input  wire                         play_en,
    output logic [NOTE_COUNT-1:0]       active_notes,
    output logic                        overrun,
    step_note_synth_if.master           snd
);

    localparam int                  DIV_W    = $clog2(SAMPLE_DIV);
    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic signed [23:0]  AMP_S    = 24'(AMP);

    // ------------------------------------------------------------------
    // bpm_step synchroniser and edge detect; the pulse is registered, so
    // it appears three clocks after the asynchronous edge.
    // ------------------------------------------------------------------
    logic [1:0] sync_q;
    logic       step_seen_q;
    logic       step_pulse_q;

    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            sync_q       <= 2'b00;
            step_seen_q  <= 1'b0;
            step_pulse_q <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], bpm_step};
            step_seen_q  <= sync_q[1];
            step_pulse_q <= sync_q[1] & ~step_seen_q;
        end
    end

    // ------------------------------------------------------------------
    // Gate FSM. note_q is only non-zero in SOUND, so it doubles as the
    // registered active_notes output.
    // ------------------------------------------------------------------
    gate_state_e           state_q;
    logic [NOTE_COUNT-1:0] note_q;
    logic [31:0]           gate_cnt_q;

    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            state_q    <= GATE_IDLE;
            note_q     <= '0;
            gate_cnt_q <= '0;
        end else begin
            case (state_q)
                GATE_IDLE: begin
                    if (step_pulse_q && play_en) begin
                        state_q    <= GATE_SOUND;
                        note_q     <= select_note;
                        gate_cnt_q <= GATE_CYCLES;
                    end
                end
                GATE_SOUND: begin
                    if (!play_en) begin
                        state_q <= GATE_IDLE;
                        note_q  <= '0;
                    end else if (step_pulse_q) begin
                        note_q     <= select_note;
                        gate_cnt_q <= GATE_CYCLES;
                    end else if (GATE_CYCLES != 0) begin
                        // The clock that takes gate_cnt to zero is the last
                        // one counted, giving exactly GATE_CYCLES of sound.
                        if (gate_cnt_q == 32'd1) begin
                            state_q <= GATE_IDLE;
                            note_q  <= '0;
                        end else begin
                            gate_cnt_q <= gate_cnt_q - 32'd1;
                        end
                    end
                end
                default: begin
                    state_q <= GATE_IDLE;
                    note_q  <= '0;
                end
            endcase
        end
    end

    assign active_notes = note_q;

    // ------------------------------------------------------------------
    // Oscillator bank
    // ------------------------------------------------------------------
    logic [NOTE_COUNT-1:0] osc_phase;

    for (genvar n = 0; n < NOTE_COUNT; n++) begin : g_osc
        tone_osc #(
            .HALF (scale_half(HALF_PERIOD[n], CLK_HZ))
        ) u_osc (
            .CLOCK_50 (CLOCK_50),
            .Reset    (Reset),
            .enable   (note_q[n]),
            .phase    (osc_phase[n])
        );
    end

    // ------------------------------------------------------------------
    // Mixer: inactive notes contribute nothing, so silence is 0, not -DC.
    // ------------------------------------------------------------------
    logic signed [23:0] mix;

    always_comb begin
        mix = '0;
        for (int n = 0; n < NOTE_COUNT; n++) begin
            if (note_q[n]) begin
                mix = mix + (osc_phase[n] ? AMP_S : -AMP_S);
            end
        end
    end

    // ------------------------------------------------------------------
    // Sample-rate divider; tick_q is high for the clock after the wrap,
    // so the handshake edge lands SAMPLE_DIV+1 clocks after reset.
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt_q;
    logic             tick_q;

    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            div_cnt_q <= '0;
            tick_q    <= 1'b0;
        end else begin
            tick_q    <= (div_cnt_q == DIV_LAST);
            div_cnt_q <= (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Codec handshake
    // ------------------------------------------------------------------
    logic signed [23:0] sample_q;
    logic               sample_valid_q;
    logic               overrun_q;

    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
        end else if (tick_q) begin
            if (!sample_valid_q) begin
                sample_q       <= mix;
                sample_valid_q <= 1'b1;
            end else if (snd.sample_ready) begin
                // Old sample leaves on this edge; the new one replaces it.
                sample_q <= mix;
            end else begin
                overrun_q <= 1'b1;
            end
        end else if (sample_valid_q && snd.sample_ready) begin
            sample_valid_q <= 1'b0;
        end
    end

    assign snd.sample       = sample_q;
    assign snd.sample_valid = sample_valid_q;
    assign overrun          = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_step_note_synth.sv
`default_nettype none
// ============================================================================
// Module      : tb_step_note_synth
// Description : Self-checking bench for step_note_synth. Expected samples come
//               from a closed-form phase model (elapsed clocks / half-period)
//               queued at every tick and compared when the codec accepts.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_step_note_synth;

    localparam int DIV = 1042;
    localparam int AMP = 600_000;
    localparam int BIG = 32'h7fff_ffff;
    localparam int HALF_TB [12] = '{95556, 90193, 85131, 80353, 75843, 71586,
                                    67568, 63776, 60196, 56818, 53629, 50619};

    logic        CLOCK_50 = 1'b0;
    logic        Reset;
    logic [11:0] select_note, select2;
    logic        bpm_step, bpm2, play_en, play2;
    logic [11:0] active_notes, active2;
    logic        overrun, overrun2;

    always #10 CLOCK_50 = ~CLOCK_50;

    step_note_synth_if snd ();
    step_note_synth_if snd2 ();

    step_note_synth dut (
        .CLOCK_50     (CLOCK_50),
        .Reset        (Reset),
        .select_note  (select_note),
        .bpm_step     (bpm_step),
        .play_en      (play_en),
        .active_notes (active_notes),
        .overrun      (overrun),
        .snd          (snd)
    );

    step_note_synth #(.GATE_CYCLES(1000)) dut_gate (
        .CLOCK_50     (CLOCK_50),
        .Reset        (Reset),
        .select_note  (select2),
        .bpm_step     (bpm2),
        .play_en      (play2),
        .active_notes (active2),
        .overrun      (overrun2),
        .snd          (snd2)
    );

    logic a4_phase;
    assign a4_phase = dut.g_osc[9].u_osc.phase;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge CLOCK_50) begin
        if (Reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Note model: note n sounds for clock edges act_edge[n] <= k < off_edge[n].
    int act_edge [12];
    int off_edge [12];

    function automatic logic signed [23:0] exp_mix(input int k);
        int s = 0;
        for (int n = 0; n < 12; n++) begin
            if (act_edge[n] >= 0 && act_edge[n] <= k && k < off_edge[n])
                s += ((((k - act_edge[n]) / HALF_TB[n]) % 2) == 1) ? AMP : -AMP;
        end
        return 24'(s);
    endfunction

    task automatic model_step(input int a, input logic [11:0] mask);
        for (int n = 0; n < 12; n++) begin
            if (mask[n] && !(act_edge[n] >= 0 && off_edge[n] == BIG)) begin
                act_edge[n] = a;
                off_edge[n] = BIG;
            end else if (!mask[n] && act_edge[n] >= 0 && off_edge[n] == BIG) begin
                off_edge[n] = a;
            end
        end
    endtask

    task automatic model_stop(input int e);
        for (int n = 0; n < 12; n++)
            if (act_edge[n] >= 0 && off_edge[n] == BIG) off_edge[n] = e;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_edge(input int k);
        while (cyc < k) @(negedge CLOCK_50);
    endtask

    // Scoreboard: push the modelled mix at every tick, pop on each transfer.
    logic signed [23:0] sb_q [$];
    bit                 sb_en = 1'b0;

    always begin
        @(negedge CLOCK_50);
        #2;
        if (!Reset && sb_en) begin
            if (cyc > 0 && (cyc % DIV) == 0) sb_q.push_back(exp_mix(cyc));
            if (snd.sample_valid && snd.sample_ready) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $error("FAIL sb_extra: observed sample %0d expected none", snd.sample);
                end else begin
                    check("sb_sample", snd.sample, sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        int e, a1, e2, m, t;

        for (int n = 0; n < 12; n++) begin
            act_edge[n] = -1;
            off_edge[n] = BIG;
        end
        Reset = 1'b1;
        select_note = '0; bpm_step = 1'b0; play_en = 1'b0;
        select2 = '0; bpm2 = 1'b0; play2 = 1'b0;
        snd.sample_ready  = 1'b1;
        snd2.sample_ready = 1'b1;

        repeat (3) @(negedge CLOCK_50);
        check("rst_active",  active_notes, 0);
        check("rst_valid",   snd.sample_valid, 0);
        check("rst_sample",  snd.sample, 0);
        check("rst_overrun", overrun, 0);
        Reset = 1'b0;
        sb_en = 1'b1;

        // First sample: valid rises 1043 clocks after release, silent.
        wait_edge(DIV);
        check("first_valid_early", snd.sample_valid, 0);
        wait_edge(DIV + 1);
        check("first_valid", snd.sample_valid, 1);
        check("first_sample", snd.sample, 0);

        // Gated instance: 1000 clocks of sound from one step.
        wait_edge(1100);
        select2 = 12'h001; play2 = 1'b1; bpm2 = 1'b1; e = cyc;
        wait_edge(e + 3);
        check("gate_early", active2, 0);
        wait_edge(e + 4);
        check("gate_on", active2, 12'h001);
        bpm2 = 1'b0;
        wait_edge(e + 4 + 999);
        check("gate_last", active2, 12'h001);
        wait_edge(e + 4 + 1000);
        check("gate_off", active2, 0);
        wait_edge(e + 4 + 1500);
        check("gate_stays_off", active2, 0);
        check("gate_overrun", overrun2, 0);

        // A4 alone.
        wait_edge(3000);
        select_note = 12'h200; play_en = 1'b1; bpm_step = 1'b1; e = cyc;
        a1 = e + 4;
        model_step(a1, 12'h200);
        wait_edge(e + 3);
        check("a4_latency_early", active_notes, 0);
        wait_edge(e + 4);
        check("a4_active", active_notes, 12'h200);
        bpm_step = 1'b0;

        // Short codec stall: sample held, then accepted once.
        m = (cyc / DIV + 2) * DIV;
        wait_edge(m);
        snd.sample_ready = 1'b0;
        wait_edge(m + 200);
        check("stall_valid", snd.sample_valid, 1);
        check("stall_sample", snd.sample, exp_mix(m));
        wait_edge(m + 300);
        snd.sample_ready = 1'b1;

        // Add C, E, G; A4 keeps its phase across the relatch.
        wait_edge(a1 + 20000);
        select_note = 12'h291; bpm_step = 1'b1; e2 = cyc;
        model_step(e2 + 4, 12'h291);
        wait_edge(e2 + 4);
        check("ceg_active", active_notes, 12'h291);
        bpm_step = 1'b0;

        wait_edge(a1 + 56817);
        check("a4_phase_before_flip", a4_phase, 0);
        wait_edge(a1 + 56818);
        check("a4_phase_flip", a4_phase, 1);

        // Overrun: ready held low across two ticks.
        t = (cyc / DIV + 2) * DIV;
        wait_edge(t - 5);
        sb_en = 1'b0;
        sb_q.delete();
        snd.sample_ready = 1'b0;
        wait_edge(t + 1);
        check("ovr_load_valid", snd.sample_valid, 1);
        check("ovr_load_sample", snd.sample, exp_mix(t));
        wait_edge(t + DIV);
        check("ovr_not_yet", overrun, 0);
        wait_edge(t + DIV + 1);
        check("ovr_set", overrun, 1);
        check("ovr_sample_held", snd.sample, exp_mix(t));
        wait_edge(t + 2 * DIV);
        snd.sample_ready = 1'b1;
        wait_edge(t + 2 * DIV + 1);
        check("tick_ready_valid", snd.sample_valid, 1);
        check("tick_ready_reload", snd.sample, exp_mix(t + 2 * DIV));
        wait_edge(t + 2 * DIV + 2);
        check("tick_ready_drained", snd.sample_valid, 0);
        check("ovr_sticky", overrun, 1);
        sb_en = 1'b1;

        // Drop play_en: silence next clock, later step ignored.
        wait_edge(cyc + 500);
        play_en = 1'b0; e = cyc;
        model_stop(e + 1);
        wait_edge(e + 1);
        check("stop_active", active_notes, 0);
        wait_edge(e + 2 * DIV);
        select_note = 12'h0F0; bpm_step = 1'b1; e = cyc;
        wait_edge(e + 6);
        check("step_no_play", active_notes, 0);
        bpm_step = 1'b0;
        wait_edge(e + 2 * DIV);

        // Reset with a pending sample clears everything.
        sb_en = 1'b0;
        snd.sample_ready = 1'b0;
        wait_edge((cyc / DIV + 1) * DIV + 2);
        check("pre_reset_valid", snd.sample_valid, 1);
        Reset = 1'b1;
        @(negedge CLOCK_50);
        check("post_reset_overrun", overrun, 0);
        check("post_reset_valid", snd.sample_valid, 0);
        check("post_reset_sample", snd.sample, 0);
        check("post_reset_active", active_notes, 0);
        Reset = 1'b0;
        repeat (2) @(negedge CLOCK_50);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
